// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame geometry and the
// command bytes the downstream decoder recognises.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS = 8;

  localparam logic [7:0] CMD_WR = 8'h55;
  localparam logic [7:0] CMD_RD = 8'haa;

endpackage

// File: rtl/sync_fall_detect.sv
// Three-flop synchronizer for an asynchronous input that idles high.
// Flops reset to 1 so a line held low through reset produces no edge until
// it has been seen high and falls again.
module sync_fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic rx_s1;
  logic rx_s2;
  logic rx_s3;

  // Two metastability flops followed by a delay flop for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every flop sample the pre-edge value,
    // so the three stages form a true shift chain rather than collapsing.
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= async_in;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign sync_out = rx_s2;
  assign fall     = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver, LSB first, mid-bit sampling from a baud counter.
// Emits a one-cycle rx_done with the byte, or a one-cycle frame_err when the
// stop bit samples low.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs232_rx,
  output logic [7:0] uart_data,
  output logic       rx_done,
  output logic       frame_err
);

  // Clocks per bit and the offset to the middle of the start bit; BAUD_CNT
  // must be at least 4 so the half-bit offset is non-trivial.
  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam int CNT_W    = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CNT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_next;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;

  logic rx_sync;
  logic rx_fall;

  logic cnt_clr;
  logic bit_take;
  logic done_set;
  logic err_set;

  sync_fall_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rs232_rx),
    .sync_out (rx_sync),
    .fall     (rx_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath controls; each state clears the counter on exit.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    cnt_clr    = 1'b0;
    bit_take   = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (rx_fall) state_next = START;
      end
      START: begin
        if (baud_cnt == HALF_END) begin
          cnt_clr    = 1'b1;
          state_next = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BIT_END) begin
          cnt_clr  = 1'b1;
          bit_take = 1'b1;
          if (bit_idx == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == BIT_END) begin
          cnt_clr    = 1'b1;
          state_next = IDLE;
          done_set   = rx_sync;
          err_set    = ~rx_sync;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Baud counter, bit index, shift register and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      uart_data <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      baud_cnt <= cnt_clr ? '0 : baud_cnt + CNT_W'(1);

      if (state != DATA)  bit_idx <= '0;
      else if (bit_take)  bit_idx <= bit_idx + 3'd1;

      if (bit_take) shift[bit_idx] <= rx_sync;

      rx_done   <= done_set;
      frame_err <= err_set;
      if (done_set) uart_data <= shift;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: directed frames on two instances (10 and 32 clocks
// per bit); a scoreboard queue per instance holds expected pulses and a
// monitor compares them whenever rx_done or frame_err fires.
module tb_uart_byte_rx;
  import uart_pkg::*;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       line_a, line_b;
  logic [7:0] data_a, data_b;
  logic       done_a, done_b;
  logic       err_a, err_b;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int checks   = 0;
  int failures = 0;

  uart_byte_rx #(.CLK_FREQ(100), .BAUD_RATE(10)) dut_a (
    .clk(clk), .rst(rst), .rs232_rx(line_a),
    .uart_data(data_a), .rx_done(done_a), .frame_err(err_a)
  );

  uart_byte_rx #(.CLK_FREQ(320), .BAUD_RATE(10)) dut_b (
    .clk(clk), .rst(rst), .rs232_rx(line_b),
    .uart_data(data_b), .rx_done(done_b), .frame_err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Hold a line level for n clocks; always returns 1 time unit after a posedge.
  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) line_b = v;
    else     line_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input int period,
                            input logic stop_bit);
    drive(sel, 1'b0, period);
    for (int i = 0; i < 8; i++) drive(sel, b[i], period);
    drive(sel, stop_bit, period);
  endtask

  task automatic expect_byte(input bit sel, input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    if (sel) sb_b.push_back(e);
    else     sb_a.push_back(e);
  endtask

  task automatic expect_err(input logic [7:0] held);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = held;
    sb_a.push_back(e);
  endtask

  // Monitor for instance A: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && (done_a || err_a)) begin
      exp_t e;
      check("a_pulse_exclusive", int'(done_a & err_a), 0);
      check("a_pulse_expected", int'(sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        check("a_pulse_kind_err", int'(err_a), int'(e.is_err));
        check("a_uart_data", int'(data_a), int'(e.data));
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!rst && (done_b || err_b)) begin
      exp_t e;
      check("b_pulse_exclusive", int'(done_b & err_b), 0);
      check("b_pulse_expected", int'(sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        check("b_pulse_kind_err", int'(err_b), int'(e.is_err));
        check("b_uart_data", int'(data_b), int'(e.data));
      end
    end
  end

  initial begin
    logic [7:0] stream [6];
    logic [7:0] aborted;
    int         wait_cnt;

    stream[0] = CMD_WR;
    stream[1] = 8'h01;
    stream[2] = 8'h02;
    stream[3] = 8'h03;
    stream[4] = 8'h04;
    stream[5] = CMD_RD;
    aborted   = 8'hC3;

    rst    = 1'b1;
    line_a = 1'b1;
    line_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("reset_uart_data", int'(data_a), 0);
    check("reset_rx_done", int'(done_a), 0);
    check("reset_frame_err", int'(err_a), 0);
    check("reset_state_idle", int'(dut_a.state), int'(IDLE));
    drive(0, 1'b1, 5);

    // Baseline byte.
    expect_byte(0, CMD_WR);
    send_frame(0, CMD_WR, 10, 1'b1);
    drive(0, 1'b1, 20);

    // Back-to-back stream with a one-bit stop and no idle gap.
    for (int i = 0; i < 6; i++) begin
      expect_byte(0, stream[i]);
      send_frame(0, stream[i], 10, 1'b1);
    end
    drive(0, 1'b1, 20);

    // Glitch shorter than half a bit is rejected.
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 20);
    check("glitch_state_idle", int'(dut_a.state), int'(IDLE));
    expect_byte(0, 8'hA5);
    send_frame(0, 8'hA5, 10, 1'b1);
    drive(0, 1'b1, 20);

    // Framing error keeps the previous byte; a long low line does not re-trigger.
    expect_byte(0, 8'h12);
    send_frame(0, 8'h12, 10, 1'b1);
    drive(0, 1'b1, 10);
    expect_err(8'h12);
    send_frame(0, 8'h3C, 10, 1'b0);
    drive(0, 1'b0, 30);
    drive(0, 1'b1, 30);
    check("frame_err_state_idle", int'(dut_a.state), int'(IDLE));

    // Reset during data bit 4 abandons the frame.
    drive(0, 1'b0, 10);
    for (int i = 0; i < 4; i++) drive(0, aborted[i], 10);
    drive(0, aborted[4], 5);
    rst    = 1'b1;
    line_a = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset_uart_data", int'(data_a), 0);
    check("midreset_rx_done", int'(done_a), 0);
    check("midreset_frame_err", int'(err_a), 0);
    check("midreset_state_idle", int'(dut_a.state), int'(IDLE));
    drive(0, 1'b1, 20);
    expect_byte(0, 8'hFF);
    send_frame(0, 8'hFF, 10, 1'b1);
    drive(0, 1'b1, 20);

    // Sender baud off by about 3% in both directions.
    expect_byte(1, 8'h96);
    send_frame(1, 8'h96, 31, 1'b1);
    drive(1, 1'b1, 40);
    expect_byte(1, 8'h96);
    send_frame(1, 8'h96, 33, 1'b1);
    drive(1, 1'b1, 40);

    // Bounded drain of both scoreboards.
    wait_cnt = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && wait_cnt < 200) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("a_scoreboard_drained", sb_a.size(), 0);
    check("b_scoreboard_drained", sb_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- UART receiver that sits directly upstream of the command decoder.
- Converts the asynchronous serial line into 8-bit bytes, each marked by a one-cycle `rx_done` pulse.
- The decoder consumes `uart_data`/`rx_done` directly. Examples: 0x55 opens a write frame, 0xaa issues a read.
- Format is 8N1, LSB first, oversampled by a free-running baud counter with mid-bit sampling.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate in bit/s.
- BAUD_CNT, CLK_FREQ/BAUD_RATE: clocks per bit (derived, not overridden). Must be at least 4.
- HALF_CNT, BAUD_CNT/2: clocks from the start edge to the mid-start-bit sample (derived).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rs232_rx  input  1  asynchronous serial line; idles high.
- uart_data  output  8  last correctly received byte.
- rx_done  output  1  one-cycle pulse; `uart_data` is valid in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - `uart_data` = 0x00, `rx_done` = 0, `frame_err` = 0.
  - State = IDLE, baud counter = 0, bit index = 0, shift register = 0x00.
  - All three synchronizer flops = 1.
- Input conditioning: 2-FF synchronizer (`rx_s1`, `rx_s2`) plus a delay flop `rx_s3`. Falling edge = `rx_s3 & ~rx_s2`. Input latency is 2 clk.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On a falling edge -> START, with baud_cnt = 0.
  - A line held low does not re-trigger; a new high-to-low transition is required.
- START:
  - baud_cnt increments each clk.
  - At baud_cnt == HALF_CNT-1, sample `rx_s2`:
    - 0 -> DATA, baud_cnt = 0, bit_idx = 0.
    - 1 -> IDLE (glitch rejected, no output pulse).
- DATA:
  - At baud_cnt == BAUD_CNT-1: shift[bit_idx] <= `rx_s2`, baud_cnt = 0, bit_idx++.
  - After bit_idx 7 is sampled -> STOP.
  - Bit 0 is the first data bit received.
- STOP:
  - At baud_cnt == BAUD_CNT-1, sample `rx_s2`:
    - 1: `uart_data` <= shift and `rx_done` = 1, both registered, visible the next clk.
    - 0: `frame_err` = 1 the next clk; `uart_data` is unchanged.
  - Either way -> IDLE in the same cycle. The rest of the stop bit is spent in IDLE, so a back-to-back start edge is caught.
- Pulse rules: `rx_done` and `frame_err` are exactly one clk wide, mutually exclusive, and at most one per frame.
- Latency: the `rx_done` rising edge occurs about (1 + 8 + 0.5) × BAUD_CNT + 3 clk after the line falling edge.
- Counter widths: the baud counter is wide enough for BAUD_CNT-1; bit index is 3 bits. No wrap occurs inside a state because each state resets the counter on exit.
- Reset mid-frame: the frame is abandoned; the next cycle shows reset values; no pulse is emitted for the partial frame.
- Line low at reset release: stays in IDLE until a high-to-low edge is seen (synchronizer resets high).
- Timing tolerance: a sender baud mismatch of up to ±3% must still decode correctly (mid-bit sampling).

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - DATA_BITS = 8.
  - Command byte constants CMD_WR = 0x55 and CMD_RD = 0xaa, also used by the decoder.
- Sub-module `sync_fall_detect`: 3-flop synchronizer with reset-to-1 and a `fall` pulse output. Reused by other async inputs.

Test Plan:
- Baseline byte: override BAUD_RATE so BAUD_CNT = 10; after reset send 0x55 -> exactly one `rx_done`, `uart_data` = 0x55, `frame_err` never asserted.
- Back-to-back stream: send 0x55, 0x01, 0x02, 0x03, 0x04, 0xaa with no idle gap (stop bit 1 bit long) -> six `rx_done` pulses, data in that order, none lost.
- Glitch rejection: drive the line low for 3 clk (< HALF_CNT = 5), then high -> no pulse, FSM back in IDLE; the following 0xA5 frame is received correctly.
- Framing error: after a good 0x12, send 0x3C with stop bit 0 -> one `frame_err` pulse, no `rx_done`, `uart_data` stays 0x12. Then hold the line low 30 clk and release -> no spurious frame.
- Reset mid-frame: assert `rst` for 1 clk during data bit 4 of 0xC3 -> next cycle outputs 0 and FSM in IDLE; the following 0xFF frame yields one `rx_done` with `uart_data` = 0xFF.
- Baud tolerance: BAUD_CNT = 32, sender bit period 31 clk and then 33 clk, sending 0x96 -> both received as 0x96.
